ahb_sram_subordinate: RTL and testbench
=======================================

// Module: ahb_sram_subordinate
// PURPOSE
// - AHB subordinate answering ahb_if manager traffic: word-addressed SRAM with byte lanes.
// - Adds programmable wait states and a two-cycle ERROR response.
// - Sits on the subordinate side of ahb_if as the DUT-side responder for VIP managers.
// - The interface SVA checkers run against it.
// PARAMETERS
// - ADDR_WIDTH   32    HADDR width
// - DATA_WIDTH   32    HWDATA/HRDATA width; 32 or 64 only
// - MEM_DEPTH    1024  memory size in DATA_WIDTH words
// - WAIT_STATES  0     HREADYOUT-low cycles inserted before every OKAY data phase; 0..15
// - PROT_BASE    768   first word index of the privileged region (used only with AHB_SUB_PROT_EN)
// PORTS
// - HCLK       in   1             clock; all logic on posedge
// - HRESET     in   1             synchronous, active-high reset
// - HSELx      in   1             subordinate select
// - HADDR      in   ADDR_WIDTH    address-phase address
// - HTRANS     in   2             IDLE=0 BUSY=1 NONSEQ=2 SEQ=3
// - HWRITE     in   1             1=write
// - HSIZE      in   3             transfer size, log2 bytes
// - HBURST     in   3             burst type; not decoded
// - HPROT      in   4             protection; HPROT[1]=privileged
// - HMASTLOCK  in   1             not decoded
// - HWDATA     in   DATA_WIDTH    write data, valid in data phase
// - HWSTRB     in   DATA_WIDTH/8  write byte strobes, valid in data phase
// - HREADY     in   1             bus ready, combined mux output
// - HRDATA     out  DATA_WIDTH    read data
// - HREADYOUT  out  1             subordinate ready
// - HRESP      out  1             0=OKAY 1=ERROR
// BEHAVIOUR
// - Reset: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0.
//   - Reset drops any pending data phase; a pending write is not committed.
//   - Memory contents are not reset.
// - Accept: at posedge with HSELx && HREADY && HTRANS[1]=1.
//   - Registers addr, write, size and prot.
//   - Data phase starts the next cycle.
// - IDLE/BUSY or HSELx=0 while HREADY=1: no data phase; next cycle HREADYOUT=1, HRESP=0.
// - Error check, done at accept; any failing check gives ERROR:
//   - HSIZE > log2(DATA_WIDTH/8)
//   - HADDR not aligned to HSIZE
//   - word index HADDR>>log2(DATA_WIDTH/8) >= MEM_DEPTH
// - FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
//   - Accept OK with WAIT_STATES=0 -> DATA.
//   - Accept OK with WAIT_STATES>0 -> WAIT, counter loaded with WAIT_STATES-1.
//   - Accept failing -> ERR1.
//   - WAIT: HREADYOUT=0, HRESP=0. Counter decrements; at 0 -> DATA.
//   - DATA: HREADYOUT=1, HRESP=0. A new accept this cycle re-enters the above; otherwise -> IDLE.
//   - ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
//   - ERR2: HREADYOUT=1, HRESP=1. New accept in ERR2 is honoured like from DATA.
//   - Error responses never insert wait states.
// - Write commit: at the posedge ending DATA.
//   - Byte enable = HWSTRB & lane_mask(size, addr low bits).
//   - ERROR transfers never write.
// - Read: HRDATA = mem[addr_q] full word, combinational, while in DATA with write_q=0; else 0.
// - Back-to-back write then read of the same word returns the new data.
//   - The write commits on the same edge that accepts the read.
// - Data phase of an ERROR transfer: HRDATA=0.
// CONFIGURATION
// - Macro AHB_SUB_PROT_EN.
// - Defined: a write with HPROT[1]=0 to word index >= PROT_BASE fails at accept -> ERR1/ERR2.
//   - Memory unchanged; reads are unaffected.
// - Undefined: HPROT is ignored and PROT_BASE is unused.
// TESTING
// - T1 WAIT_STATES=0: word write 0xDEADBEEF @0x10, then read @0x10 back-to-back.
//   -> HRDATA=0xDEADBEEF, HRESP=0, HREADYOUT never low.
// - T2 Byte write 0xAA @0x13 (HSIZE=0, HWSTRB=4'b1000), then read @0x10 -> 0xAAADBEEF.
// - T3 WAIT_STATES=2: read @0x10.
//   -> HREADYOUT 0,0,1 across data phase; HRDATA valid only on the HREADYOUT=1 cycle.
// - T4 Word read @0x02 (misaligned) -> cycle1 HREADYOUT=0/HRESP=1, cycle2 HREADYOUT=1/HRESP=1, HRDATA=0.
// - T5 MEM_DEPTH=1024: write @0x1000 -> two-cycle ERROR.
//   - Then read @0x0 returns the prior contents, unchanged.
// - T6 Reset mid-WAIT of a write 0x12345678 @0x20.
//   -> next cycle HREADYOUT=1/HRESP=0; later read @0x20 shows the old value.
// - With AHB_SUB_PROT_EN, PROT_BASE=768:
//   - write @0xC00 with HPROT=4'b0001 -> ERROR.
//   - same write with HPROT=4'b0011 -> OKAY.

Source files
------------

// File: rtl/ahb_sram_subordinate.sv
// AHB subordinate wrapping a word-addressed SRAM with byte lanes.
// Adds programmable wait states before every OKAY data phase and a
// two-cycle ERROR response for bad size, misalignment or out-of-range access.
// Optional feature macro: AHB_SUB_PROT_EN (unprivileged writes at or above
// PROT_BASE are rejected with ERROR).
module ahb_sram_subordinate #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_DEPTH   = 1024,
   parameter int WAIT_STATES = 0,
   parameter int PROT_BASE   = 768
) (
   input  logic                    HCLK,
   input  logic                    HRESET,
   input  logic                    HSELx,
   input  logic [ADDR_WIDTH-1:0]   HADDR,
   input  logic [1:0]              HTRANS,
   input  logic                    HWRITE,
   input  logic [2:0]              HSIZE,
   input  logic [2:0]              HBURST,
   input  logic [3:0]              HPROT,
   input  logic                    HMASTLOCK,
   input  logic [DATA_WIDTH-1:0]   HWDATA,
   input  logic [DATA_WIDTH/8-1:0] HWSTRB,
   input  logic                    HREADY,
   output logic [DATA_WIDTH-1:0]   HRDATA,
   output logic                    HREADYOUT,
   output logic                    HRESP
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int LOG2B = $clog2(BYTES);
   localparam int MIDX  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_DATA,
      S_ERR1,
      S_ERR2
   } state_t;

   state_t state, state_d;
   logic [3:0] cnt, cnt_d;
   logic take;

   logic [MIDX-1:0]       word_q;
   logic [LOG2B-1:0]      low_q;
   logic [2:0]            size_q;
   logic [3:0]            prot_q;
   logic                  write_q;

   logic                  accept;
   logic [ADDR_WIDTH-1:0] word_idx;
   logic [LOG2B-1:0]      align_mask;
   logic                  size_bad, align_bad, range_bad, prot_bad, acc_err;
   logic [BYTES-1:0]      byte_en;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   logic unused_ok;
   assign unused_ok = ^{HBURST, HMASTLOCK, HTRANS[0], prot_q};

   assign accept   = HSELx & HREADY & HTRANS[1];
   assign word_idx = HADDR >> LOG2B;

   // Low address bits that must be zero for the requested transfer size
   always_comb begin
      align_mask = '0;
      for (int i = 0; i < LOG2B; i++) begin
         align_mask[i] = (3'(i) < HSIZE);
      end
   end

   // Address-phase legality checks; any failure turns the transfer into ERROR
   always_comb begin
      size_bad  = (HSIZE > 3'(LOG2B));
      align_bad = |(HADDR[LOG2B-1:0] & align_mask);
      range_bad = (word_idx >= ADDR_WIDTH'(MEM_DEPTH));
`ifdef AHB_SUB_PROT_EN
      prot_bad  = HWRITE & ~HPROT[1] & (word_idx >= ADDR_WIDTH'(PROT_BASE));
`else
      prot_bad  = 1'b0;
`endif
      acc_err   = size_bad | align_bad | range_bad | prot_bad;
   end

   // Next-state logic and the handshake outputs decoded from the current state
   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      take      = 1'b0;
      HREADYOUT = 1'b1;
      HRESP     = 1'b0;
      case (state)
         S_WAIT: begin
            HREADYOUT = 1'b0;
            if (cnt == 4'd0) begin
               state_d = S_DATA;
            end else begin
               cnt_d = cnt - 4'd1;
            end
         end
         S_ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = 1'b1;
            state_d   = S_ERR2;
         end
         default: begin
            HRESP = (state == S_ERR2);
            if (accept) begin
               take = 1'b1;
               if (acc_err) begin
                  state_d = S_ERR1;
               end else if (WAIT_STATES == 0) begin
                  state_d = S_DATA;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = WAIT_LOAD;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
      endcase
   end

   // State register and wait counter; reset abandons any pending data phase
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state   <= S_IDLE;
         cnt     <= 4'd0;
         write_q <= 1'b0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         if (take) begin
            write_q <= HWRITE;
         end
      end
   end

   // Address-phase capture of the accepted transfer
   always_ff @(posedge HCLK) begin
      if (take) begin
         word_q <= HADDR[LOG2B +: MIDX];
         low_q  <= HADDR[LOG2B-1:0];
         size_q <= HSIZE;
         prot_q <= HPROT;
      end
   end

   // Byte lanes covered by the transfer, qualified by the write strobes
   always_comb begin
      byte_en = '0;
      for (int b = 0; b < BYTES; b++) begin
         if ((b >> size_q) == (int'(low_q) >> size_q)) begin
            byte_en[b] = HWSTRB[b];
         end
      end
   end

   // Commit write data at the edge that ends an OKAY write data phase
   always_ff @(posedge HCLK) begin
      if (!HRESET && state == S_DATA && write_q) begin
         for (int b = 0; b < BYTES; b++) begin
            if (byte_en[b]) begin
               mem[word_q][8*b +: 8] <= HWDATA[8*b +: 8];
            end
         end
      end
   end

   // Read data is presented only during an OKAY read data phase
   always_comb begin
      HRDATA = '0;
      if (state == S_DATA && !write_q) begin
         HRDATA = mem[word_q];
      end
   end

endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// Self-checking bench for ahb_sram_subordinate: one instance without wait
// states, one with two wait states, driven by a pipelined AHB manager task.
module tb_ahb_sram_subordinate;

   typedef struct {
      string       name;
      logic        write;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [3:0]  strb;
      logic [31:0] wdata;
      logic [3:0]  prot;
      logic        exp_resp;
      logic [31:0] exp_rdata;
      int          exp_waits;
   } xfer_t;

   logic        clk = 1'b0;
   logic        hreset = 1'b1;
   logic        hsel [2];
   logic [31:0] haddr [2];
   logic [1:0]  htrans [2];
   logic        hwrite [2];
   logic [2:0]  hsize [2];
   logic [3:0]  hprot [2];
   logic [31:0] hwdata [2];
   logic [3:0]  hwstrb [2];
   logic [31:0] hrdata [2];
   logic        hreadyout [2];
   logic        hresp [2];

   int total = 0;
   int bad = 0;

   xfer_t vec [$];
   xfer_t stim_q [$];
   xfer_t exp_q [$];

   always #5 clk = ~clk;

   ahb_sram_subordinate #(.WAIT_STATES(0)) dut0 (
      .HCLK(clk), .HRESET(hreset), .HSELx(hsel[0]), .HADDR(haddr[0]),
      .HTRANS(htrans[0]), .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(3'd0),
      .HPROT(hprot[0]), .HMASTLOCK(1'b0), .HWDATA(hwdata[0]), .HWSTRB(hwstrb[0]),
      .HREADY(hreadyout[0]), .HRDATA(hrdata[0]), .HREADYOUT(hreadyout[0]),
      .HRESP(hresp[0])
   );

   ahb_sram_subordinate #(.WAIT_STATES(2)) dut1 (
      .HCLK(clk), .HRESET(hreset), .HSELx(hsel[1]), .HADDR(haddr[1]),
      .HTRANS(htrans[1]), .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(3'd0),
      .HPROT(hprot[1]), .HMASTLOCK(1'b0), .HWDATA(hwdata[1]), .HWSTRB(hwstrb[1]),
      .HREADY(hreadyout[1]), .HRDATA(hrdata[1]), .HREADYOUT(hreadyout[1]),
      .HRESP(hresp[1])
   );

   function automatic xfer_t mk(input string name, input logic write,
                                input logic [31:0] addr, input logic [2:0] size,
                                input logic [3:0] strb, input logic [31:0] wdata,
                                input logic [3:0] prot, input logic exp_resp,
                                input logic [31:0] exp_rdata, input int exp_waits);
      xfer_t x;
      x.name = name; x.write = write; x.addr = addr; x.size = size;
      x.strb = strb; x.wdata = wdata; x.prot = prot; x.exp_resp = exp_resp;
      x.exp_rdata = exp_rdata; x.exp_waits = exp_waits;
      return x;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic idleBus(input int d);
      hsel[d] = 1'b0; htrans[d] = 2'd0; haddr[d] = '0; hwrite[d] = 1'b0;
      hsize[d] = 3'd2; hprot[d] = 4'd3; hwdata[d] = '0; hwstrb[d] = 4'h0;
   endtask

   // Pipelined manager: drives stim_q onto DUT d, scoreboard check on completion.
   // Entered and left at posedge+1.
   task automatic applyStimulus(input int d);
      xfer_t cur;
      xfer_t done;
      bit    inflight = 0;
      bit    ready_now;
      int    waits = 0;
      bit    lowresp_bad = 0;
      bit    lowrdata_bad = 0;
      int    budget = 0;
      exp_q.delete();
      while ((stim_q.size() > 0 || inflight) && budget < 500) begin
         if (stim_q.size() > 0) begin
            cur = stim_q[0];
            hsel[d] = 1'b1; htrans[d] = 2'd2; haddr[d] = cur.addr;
            hwrite[d] = cur.write; hsize[d] = cur.size; hprot[d] = cur.prot;
         end else begin
            hsel[d] = 1'b0; htrans[d] = 2'd0;
         end
         if (inflight) begin
            hwdata[d] = exp_q[0].wdata;
            hwstrb[d] = exp_q[0].strb;
         end
         @(negedge clk);
         if (inflight) begin
            if (hreadyout[d]) begin
               done = exp_q.pop_front();
               checkOutput({done.name, " resp"}, 32'(hresp[d]), 32'(done.exp_resp));
               checkOutput({done.name, " rdata"}, hrdata[d], done.exp_rdata);
               checkOutput({done.name, " waits"}, waits, done.exp_waits);
               checkOutput({done.name, " lowresp"}, 32'(lowresp_bad), 32'd0);
               checkOutput({done.name, " lowrdata"}, 32'(lowrdata_bad), 32'd0);
               inflight = 0;
            end else begin
               waits++;
               if (hresp[d] !== exp_q[0].exp_resp) lowresp_bad = 1;
               if (hrdata[d] !== 32'd0) lowrdata_bad = 1;
            end
         end
         ready_now = hreadyout[d];
         @(posedge clk);
         if (ready_now && stim_q.size() > 0) begin
            exp_q.push_back(stim_q.pop_front());
            inflight = 1;
            waits = 0;
            lowresp_bad = 0;
            lowrdata_bad = 0;
         end
         #1;
         budget++;
      end
      if (budget >= 500) begin
         total++;
         bad++;
         $display("[TB] FAIL timeout dut%0d actual=%0d required=<500 cycles", d, budget);
         stim_q.delete();
      end
      idleBus(d);
   endtask

   initial begin
      idleBus(0);
      idleBus(1);
      hreset = 1'b1;
      repeat (3) @(posedge clk);
      #1 hreset = 1'b0;

      // Reset state of both instances
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checkOutput($sformatf("reset hreadyout dut%0d", d), 32'(hreadyout[d]), 32'd1);
         checkOutput($sformatf("reset hresp dut%0d", d), 32'(hresp[d]), 32'd0);
         checkOutput($sformatf("reset hrdata dut%0d", d), hrdata[d], 32'd0);
      end
      @(posedge clk);
      #1;

      // Main vector table, zero wait states
      vec.push_back(mk("w0",      1, 32'h0,    3'd2, 4'hF, 32'h01020304, 4'h3, 0, 32'h0, 0));
      vec.push_back(mk("t1_w",    1, 32'h10,   3'd2, 4'hF, 32'hDEADBEEF, 4'h3, 0, 32'h0, 0));
      vec.push_back(mk("t1_r",    0, 32'h10,   3'd2, 4'h0, 32'h0,        4'h3, 0, 32'hDEADBEEF, 0));
      vec.push_back(mk("t2_wb",   1, 32'h13,   3'd0, 4'h8, 32'hAA000000, 4'h3, 0, 32'h0, 0));
      vec.push_back(mk("t2_r",    0, 32'h10,   3'd2, 4'h0, 32'h0,        4'h3, 0, 32'hAAADBEEF, 0));
      vec.push_back(mk("t4_mis",  0, 32'h02,   3'd2, 4'h0, 32'h0,        4'h3, 1, 32'h0, 1));
      vec.push_back(mk("t5_oor",  1, 32'h1000, 3'd2, 4'hF, 32'h55555555, 4'h3, 1, 32'h0, 1));
      vec.push_back(mk("t5_r0",   0, 32'h0,    3'd2, 4'h0, 32'h0,        4'h3, 0, 32'h01020304, 0));
      vec.push_back(mk("hw_base", 1, 32'h14,   3'd2, 4'hF, 32'h11223344, 4'h3, 0, 32'h0, 0));
      vec.push_back(mk("hw_w",    1, 32'h16,   3'd1, 4'hF, 32'hCAFE9999, 4'h3, 0, 32'h0, 0));
      vec.push_back(mk("hw_r",    0, 32'h14,   3'd2, 4'h0, 32'h0,        4'h3, 0, 32'hCAFE3344, 0));
      vec.push_back(mk("size64",  0, 32'h18,   3'd3, 4'h0, 32'h0,        4'h3, 1, 32'h0, 1));
      vec.push_back(mk("top_w",   1, 32'hFFC,  3'd2, 4'hF, 32'h0BADF00D, 4'h3, 0, 32'h0, 0));
      vec.push_back(mk("top_r",   0, 32'hFFC,  3'd2, 4'h0, 32'h0,        4'h3, 0, 32'h0BADF00D, 0));
      vec.push_back(mk("prot_w3", 1, 32'hC00,  3'd2, 4'hF, 32'h12121212, 4'h3, 0, 32'h0, 0));
`ifdef AHB_SUB_PROT_EN
      vec.push_back(mk("prot_w1", 1, 32'hC00,  3'd2, 4'hF, 32'h77777777, 4'h1, 1, 32'h0, 1));
      vec.push_back(mk("prot_r",  0, 32'hC00,  3'd2, 4'h0, 32'h0,        4'h1, 0, 32'h12121212, 0));
`else
      vec.push_back(mk("prot_w1", 1, 32'hC00,  3'd2, 4'hF, 32'h77777777, 4'h1, 0, 32'h0, 0));
      vec.push_back(mk("prot_r",  0, 32'hC00,  3'd2, 4'h0, 32'h0,        4'h1, 0, 32'h77777777, 0));
`endif
      for (int i = 0; i < vec.size(); i++) begin
         stim_q.push_back(vec[i]);
      end
      applyStimulus(0);

      // Bus idle afterwards: ready, OKAY, no read data
      @(negedge clk);
      checkOutput("idle hreadyout", 32'(hreadyout[0]), 32'd1);
      checkOutput("idle hresp", 32'(hresp[0]), 32'd0);
      checkOutput("idle hrdata", hrdata[0], 32'd0);
      @(posedge clk);
      #1;

      // Two wait states: write/read back-to-back, error without waits
      stim_q.push_back(mk("t3_w",   1, 32'h10, 3'd2, 4'hF, 32'hDEADBEEF, 4'h3, 0, 32'h0, 2));
      stim_q.push_back(mk("t3_r",   0, 32'h10, 3'd2, 4'h0, 32'h0,        4'h3, 0, 32'hDEADBEEF, 2));
      stim_q.push_back(mk("t3_err", 0, 32'h12, 3'd2, 4'h0, 32'h0,        4'h3, 1, 32'h0, 1));
      stim_q.push_back(mk("t6_pre", 1, 32'h20, 3'd2, 4'hF, 32'hA5A5A5A5, 4'h3, 0, 32'h0, 2));
      applyStimulus(1);

      // Reset during the wait phase of a write must drop the write
      hsel[1] = 1'b1; htrans[1] = 2'd2; haddr[1] = 32'h20; hwrite[1] = 1'b1;
      hsize[1] = 3'd2; hprot[1] = 4'h3;
      @(posedge clk);
      #1;
      hsel[1] = 1'b0; htrans[1] = 2'd0; hwdata[1] = 32'h12345678; hwstrb[1] = 4'hF;
      @(negedge clk);
      checkOutput("t6 in wait", 32'(hreadyout[1]), 32'd0);
      hreset = 1'b1;
      @(posedge clk);
      #1;
      hreset = 1'b0;
      idleBus(1);
      @(negedge clk);
      checkOutput("t6 hreadyout", 32'(hreadyout[1]), 32'd1);
      checkOutput("t6 hresp", 32'(hresp[1]), 32'd0);
      @(posedge clk);
      #1;
      stim_q.push_back(mk("t6_r", 0, 32'h20, 3'd2, 4'h0, 32'h0, 4'h3, 0, 32'hA5A5A5A5, 2));
      applyStimulus(1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
